// File: rtl/fxp_div.sv
// Signed Q(N-FRAC).FRAC fixed-point divider: restoring shift-subtract over N+FRAC cycles,
// with saturation and divide-by-zero flags registered alongside the quotient.
module fxp_div #(
  parameter int unsigned N    = 20,
  parameter int unsigned FRAC = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] y,
  output logic         overflow,
  output logic         div_by_zero
);

  localparam int unsigned W  = N + FRAC;
  localparam int unsigned CW = $clog2(W);

  localparam logic [W-1:0] PosMax = W'((64'd1 << (N - 1)) - 64'd1);
  localparam logic [W-1:0] NegMag = W'(64'd1 << (N - 1));
  localparam logic [N-1:0] MaxY   = {1'b0, {(N - 1){1'b1}}};
  localparam logic [N-1:0] MinY   = {1'b1, {(N - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  mag_b_q, mag_b_d;
  logic [W-1:0]  dvd_q, dvd_d;     // dividend bits shift out the top, quotient bits in the bottom
  logic [N-1:0]  rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sign_q, sign_d;
  logic [N-1:0]  y_q, y_d;
  logic          ovf_q, ovf_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    rem_sh;
  logic [N-1:0]  diff;
  logic          qbit;
  logic [W-1:0]  q_next;
  logic [N-1:0]  q_lo;
  logic [N-1:0]  mag_a;

  assign rem_sh = {rem_q, dvd_q[W-1]};
  assign qbit   = rem_sh >= {1'b0, mag_b_q};
  assign diff   = rem_sh[N-1:0] - mag_b_q;
  assign q_next = {dvd_q[W-2:0], qbit};
  assign q_lo   = q_next[N-1:0];
  assign mag_a  = a[N-1] ? -a : a;

  always_comb begin
    state_d = state_q;
    mag_b_d = mag_b_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (b == '0) begin
            y_d     = a[N-1] ? MinY : MaxY;
            ovf_d   = 1'b0;
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            mag_b_d = b[N-1] ? -b : b;
            dvd_d   = W'(mag_a) << FRAC;
            rem_d   = '0;
            cnt_d   = '0;
            sign_d  = a[N-1] ^ b[N-1];
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d = qbit ? diff : rem_sh[N-1:0];
        dvd_d = q_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          dbz_d   = 1'b0;
          state_d = StDone;
          // Negative results may reach exactly 2^(N-1) without saturating.
          if (sign_q) begin
            ovf_d = q_next > NegMag;
            y_d   = ovf_d ? MinY : -q_lo;
          end else begin
            ovf_d = q_next > PosMax;
            y_d   = ovf_d ? MaxY : q_lo;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mag_b_q <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_b_q <= mag_b_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = state_q != StIdle;
  assign done        = state_q == StDone;
  assign y           = y_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fxp_div.sv
// Directed bench for fxp_div: known quotients, saturation, divide-by-zero, start during
// an operation and reset mid-calculation.
module tb_fxp_div;

  localparam int unsigned N    = 20;
  localparam int unsigned FRAC = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a, b;
  logic         busy, done, overflow, div_by_zero;
  logic [N-1:0] y;

  int checks = 0;
  int errors = 0;

  fxp_div #(.N(N), .FRAC(FRAC)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .y           (y),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ys();
    return int'($signed(y));
  endfunction

  // One division; operands are scrambled right after capture to show they are not reused.
  task automatic run(input string tag, input int av, input int bv, input int ey,
                     input int eo, input int ez, input int elat);
    int cyc;
    @(negedge clk);
    a = N'(av);
    b = N'(bv);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~a;
    b = b ^ N'(1);
    chk({tag, "_busy1"}, int'(busy), 1);
    cyc = 1;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_lat"}, cyc, elat);
    chk({tag, "_y"}, ys(), ey);
    chk({tag, "_ovf"}, int'(overflow), eo);
    chk({tag, "_dbz"}, int'(div_by_zero), ez);
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, int'({busy, done}), 0);
    chk({tag, "_hold"}, ys(), ey);
  endtask

  initial begin
    int ndone;
    int ylast;
    int first_done;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_y", ys(), 0);
    chk("rst_flags", int'({overflow, div_by_zero}), 0);
    @(negedge clk);
    rst = 1'b0;

    run("pos_div", 3072, 2048, 1536, 0, 0, 31);
    run("neg_trunc", -1024, 3072, -341, 0, 0, 31);
    run("neg_one", -2048, 2048, -1024, 0, 0, 31);
    run("pos_sat", 524287, 1, 524287, 1, 0, 31);
    run("neg_edge", -524288, 1024, -524288, 0, 0, 31);
    run("neg_sat", -524288, 1, -524288, 1, 0, 31);
    run("zero_q", 0, -3072, 0, 0, 0, 31);
    run("dbz_neg", -5, 0, -524288, 0, 1, 1);
    run("dbz_pos", 7, 0, 524287, 0, 1, 1);

    // Second start during CALC must be dropped.
    @(negedge clk);
    a = N'(3072);
    b = N'(2048);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    ylast = 0;
    first_done = 0;
    for (int i = 1; i <= 45; i++) begin
      if (done) begin
        ndone++;
        ylast = ys();
        if (first_done == 0) first_done = i;
      end
      @(negedge clk);
      start = (i == 4);
      a = N'(100);
      b = N'(1);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("restart_ndone", ndone, 1);
    chk("restart_lat", first_done, 31);
    chk("restart_y", ylast, 1536);

    // Reset in the middle of CALC.
    @(negedge clk);
    a = N'(-1024);
    b = N'(3072);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_y", ys(), 0);
    chk("midrst_flags", int'({overflow, div_by_zero}), 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    chk("midrst_quiet", ndone, 0);
    run("after_rst", 3072, 2048, 1536, 0, 0, 31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fxp_div.md
FXP_DIV -- requirements
Module: fxp_div

Interface
REQ-001 Parameter N, default 20: total signed fixed-point word width, two's complement.
REQ-002 Parameter FRAC, default 10: number of fractional bits, Q(N-FRAC).FRAC; 1.0 = 2^FRAC.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request a division; sampled only in IDLE.
REQ-006 a  input  N  signed dividend, Q format; sampled with start.
REQ-007 b  input  N  signed divisor, Q format; sampled with start.
REQ-008 busy  output  1  high while an operation is in flight (CALC or DONE).
REQ-009 done  output  1  one-cycle pulse; y and the flags are valid from this cycle.
REQ-010 y  output  N  signed quotient a/b in the same Q format; registered.
REQ-011 overflow  output  1  the quotient was saturated; registered with y.
REQ-012 div_by_zero  output  1  b was 0; registered with y.

Function
REQ-013 The block SHALL be an FSM with states IDLE, CALC and DONE.
REQ-014 IDLE with start=1 and b!=0 SHALL capture the operands and go to CALC.
REQ-015 IDLE with start=1 and b==0 SHALL go directly to DONE.
REQ-016 start in CALC or DONE SHALL be ignored, with no queuing.
REQ-017 Operands on capture: |a| and |b| as N-bit unsigned magnitudes (|-2^(N-1)| = 2^(N-1)); result sign = a[N-1] XOR b[N-1].
REQ-018 CALC SHALL run a restoring shift-subtract division of the dividend |a| << FRAC (N+FRAC bits) by |b|.
REQ-019 CALC SHALL produce one quotient bit per cycle, N+FRAC cycles total, with an (N+1)-bit partial remainder.
REQ-020 The quotient SHALL be truncated toward zero; the remainder is discarded.
REQ-021 On the last CALC cycle the FSM SHALL go to DONE and register y, overflow and div_by_zero.
REQ-022 Saturation, result positive: if the magnitude is > 2^(N-1)-1, y = 2^(N-1)-1 and overflow=1.
REQ-023 Saturation, result negative: if the magnitude is > 2^(N-1), y = -2^(N-1) and overflow=1; a magnitude of exactly 2^(N-1) SHALL NOT flag overflow.
REQ-024 A zero-magnitude quotient SHALL give y=0 regardless of the sign bits.
REQ-025 Divide by zero: y = 2^(N-1)-1 if a>=0, else -2^(N-1); div_by_zero=1 and overflow=0.
REQ-026 done=1 in the DONE state only, for exactly one cycle; the next edge SHALL return the FSM to IDLE.
REQ-027 Latency, b!=0: done SHALL be high N+FRAC+1 cycles after the edge that sampled start (31 at the defaults).
REQ-028 Latency, b==0: done SHALL be high 1 cycle after the edge that sampled start.
REQ-029 busy SHALL be high in CALC and DONE and low in IDLE; a new start SHALL be accepted the cycle after done.
REQ-030 y, overflow and div_by_zero SHALL hold their values until the next DONE.
REQ-031 Changes on a and b after capture SHALL NOT affect the result in flight.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE and y=0, done=0, busy=0, overflow=0, div_by_zero=0, and clear the internal registers.
REQ-033 rst asserted mid-CALC SHALL discard the operation; no done SHALL follow after release.
REQ-034 The first start after rst is released SHALL be processed normally.

Verification
REQ-035 a=3072 (3.0), b=2048 (2.0), start 1 cycle -> done at cycle 31, y=1536 (1.5), flags 0; busy high cycles 1..31.
REQ-036 a=-1024 (-1.0), b=3072 (3.0) -> y=-341 (truncated toward zero), overflow=0; a=-2048, b=2048 -> y=-1024.
REQ-037 a=524287, b=1 -> y=524287, overflow=1; a=-524288, b=1024 -> y=-524288, overflow=0.
REQ-038 a=-5, b=0 -> done 1 cycle after start, y=-524288, div_by_zero=1, overflow=0; a=7, b=0 -> y=524287.
REQ-039 start, then start pulsed again at cycle 5 with different operands -> only the first result, a single done pulse.
REQ-040 rst asserted at CALC cycle 10 -> all outputs 0 at once, no done; a new start after release gives the correct result at cycle 31.
